// File: rtl/ram_sync_clr_if.sv
// ram_sync_clr_if: access bus of the ram_sync_clr scratch memory.
//   master: drives req, we, oe, clr, a, din; observes dout, dvalid, busy, aerr, perr.
//   slave : the memory side (the ram_sync_clr instance).
// Parameters DATA_W / ADDR_W must match those of the attached memory.
interface ram_sync_clr_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic              req;     // access request, sampled on rising clk
  logic              we;      // 1 = write, 0 = read (with req)
  logic              oe;      // output enable for dout (combinational)
  logic              clr;     // single-cycle pulse: start a clear sweep
  logic [ADDR_W-1:0] a;       // word address
  logic [DATA_W-1:0] din;     // write data
  logic [DATA_W-1:0] dout;    // registered read data, all z when oe = 0
  logic              dvalid;  // one-cycle pulse: dout carries new read data
  logic              busy;    // clear sweep in progress, accesses ignored
  logic              aerr;    // one-cycle pulse: accepted access out of range
  logic              perr;    // one-cycle pulse: stored parity mismatch on read

  modport master (
    output req, we, oe, clr, a, din,
    input  dout, dvalid, busy, aerr, perr
  );

  modport slave (
    input  req, we, oe, clr, a, din,
    output dout, dvalid, busy, aerr, perr
  );
endinterface

// File: rtl/ram_sync_clr.sv
// ram_sync_clr: parametrised single-port synchronous scratch RAM.
//   - Registered read (1-cycle latency) with a dvalid strobe.
//   - Hardware clear sweep writing CLEAR_VAL to every word; busy while running.
//     A sweep runs out of reset and on every clr pulse.
//   - Out-of-range detection (a >= DEPTH) with a one-cycle aerr pulse.
//   - Optional even-parity per word, enabled by defining macro RAM_PARITY_EN.
//     Without it the array is DATA_W wide and perr stays 0; ports are identical.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous reset, active-high
//   bus  : ram_sync_clr_if.slave (req, we, oe, clr, a, din -> dout, dvalid,
//          busy, aerr, perr)
module ram_sync_clr #(
  parameter int                DATA_W    = 4,
  parameter int                ADDR_W    = 4,
  parameter int                DEPTH     = 16,
  parameter logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  ram_sync_clr_if.slave bus
);

  // Range check is done one bit wider than the address so that
  // DEPTH = 2**ADDR_W is representable and never flags an error.
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Even parity of a data word.
  function automatic logic parity_f(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;

  // Stored word layout: {parity, data}.
  function automatic logic [MEM_W-1:0] make_word(input logic [DATA_W-1:0] d);
    return {parity_f(d), d};
  endfunction
`else
  localparam int MEM_W = DATA_W;

  function automatic logic [MEM_W-1:0] make_word(input logic [DATA_W-1:0] d);
    return d;
  endfunction
`endif

  localparam logic [MEM_W-1:0] CLEAR_WORD = make_word(CLEAR_VAL);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Storage is deliberately not reset; the sweep initialises it.
  logic [MEM_W-1:0]  mem [DEPTH];

  state_t            state_r, state_nx;
  logic [ADDR_W-1:0] cnt_r, cnt_nx;
  logic              busy_r;
  logic [DATA_W-1:0] dout_r;
  logic              dvalid_r;
  logic              aerr_r;
  logic              perr_r;

  logic              in_range_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [MEM_W-1:0]  mem_wdata_s;
  logic              rd_en_s;
  logic              acc_s;
  logic [MEM_W-1:0]  rd_word_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              perr_s;

  // Address range check and read-path data (out-of-range reads return 0).
  always_comb begin
    in_range_s = ({1'b0, bus.a} < DEPTH_W);
    rd_word_s  = mem[bus.a];
    if (in_range_s) begin
      rd_data_s = rd_word_s[DATA_W-1:0];
    end else begin
      rd_data_s = {DATA_W{1'b0}};
    end
  end

`ifdef RAM_PARITY_EN
  // Recomputed parity against the stored bit; out-of-range reads never flag.
  always_comb begin
    if (in_range_s) begin
      perr_s = (parity_f(rd_word_s[DATA_W-1:0]) != rd_word_s[DATA_W]);
    end else begin
      perr_s = 1'b0;
    end
  end
`else
  // Parity disabled: the error path is constant.
  always_comb begin
    perr_s = 1'b0;
  end
`endif

  // Next-state, sweep counter and access decode.
  always_comb begin
    state_nx    = state_r;
    cnt_nx      = cnt_r;
    mem_we_s    = 1'b0;
    mem_waddr_s = cnt_r;
    mem_wdata_s = CLEAR_WORD;
    rd_en_s     = 1'b0;
    acc_s       = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        // One word per cycle; requests are ignored while sweeping.
        mem_we_s = 1'b1;
        if (bus.clr) begin
          cnt_nx = {ADDR_W{1'b0}};
        end else if (cnt_r == LAST_ADDR) begin
          state_nx = ST_IDLE;
          cnt_nx   = {ADDR_W{1'b0}};
        end else begin
          cnt_nx = cnt_r + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        // clr wins over a same-cycle request, which is dropped.
        if (bus.clr) begin
          state_nx = ST_CLEAR;
          cnt_nx   = {ADDR_W{1'b0}};
        end else if (bus.req) begin
          acc_s = 1'b1;
          if (bus.we) begin
            mem_we_s    = in_range_s;
            mem_waddr_s = bus.a;
            mem_wdata_s = make_word(bus.din);
          end else begin
            rd_en_s = 1'b1;
          end
        end else begin
          acc_s = 1'b0;
        end
      end
      default: begin
        state_nx = ST_CLEAR;
        cnt_nx   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Control and output registers; reset restarts the sweep from address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_CLEAR;
      cnt_r    <= {ADDR_W{1'b0}};
      busy_r   <= 1'b1;
      dout_r   <= {DATA_W{1'b0}};
      dvalid_r <= 1'b0;
      aerr_r   <= 1'b0;
      perr_r   <= 1'b0;
    end else begin
      state_r  <= state_nx;
      cnt_r    <= cnt_nx;
      busy_r   <= (state_nx == ST_CLEAR);
      dvalid_r <= rd_en_s;
      aerr_r   <= acc_s & ~in_range_s;
      perr_r   <= rd_en_s & perr_s;
      if (rd_en_s) begin
        dout_r <= rd_data_s;
      end
    end
  end

  // Single write port shared by the sweep and accepted writes.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // oe gates only the driver; the read register is unaffected.
  assign bus.dout   = bus.oe ? dout_r : {DATA_W{1'bz}};
  assign bus.dvalid = dvalid_r;
  assign bus.busy   = busy_r;
  assign bus.aerr   = aerr_r;
  assign bus.perr   = perr_r;

endmodule
